// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - UART transmitter with word FIFO, start/data/stop framing
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   data_in         word to queue
//   data_valid_in   data_in offered this cycle
//   data_ready_out  FIFO has room this cycle
//   tx_wire_out     registered serial line, idles high
//   busy_out        frame on the line or words queued
//   fifo_count_out  words currently queued
module uart_transmit #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_valid_in,
    output logic                          data_ready_out,
    output logic                          tx_wire_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BW = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_BIT_PERIOD - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         baud_cnt;
    logic [IW-1:0]         bit_idx;
    logic                  push;
    logic                  pop;
    logic                  baud_last;
    logic                  fifo_empty;

    assign data_ready_out = !rst_in && (fifo_count_out != FIFO_FULL);
    assign push           = data_valid_in && data_ready_out;
    assign fifo_empty     = (fifo_count_out == '0);
    assign baud_last      = (baud_cnt == BAUD_LAST);
    // A word leaves the FIFO either from idle or on the last stop-bit cycle,
    // the latter giving zero-gap back-to-back frames.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));

    // Storage needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count_out <= '0;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            tx_wire_out    <= 1'b1;
            busy_out       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                shift_reg <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count_out <= fifo_count_out + CW'(1);
                2'b01:   fifo_count_out <= fifo_count_out - CW'(1);
                default: fifo_count_out <= fifo_count_out;
            endcase

            // Line level follows the state one cycle late, so every level is held
            // for exactly one baud period and the pin comes straight from a flop.
            tx_wire_out <= (state == START) ? 1'b0 :
                           (state == DATA)  ? shift_reg[0] : 1'b1;
            busy_out    <= (state != IDLE) || !fifo_empty;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + IW'(1);
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= pop ? START : IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - self-checking bench for uart_transmit
module tb_uart_transmit;

    localparam int DW    = 8;
    localparam int BP    = 10;
    localparam int DEPTH = 4;
    localparam int FRAME = (DW + 2) * BP;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] din    = '0;
    logic       dvalid = 1'b0;
    logic       dready;
    logic       tx;
    logic       busy;
    logic [2:0] fcount;

    always #5 clk = ~clk;

    uart_transmit #(
        .INPUT_CLOCK_FREQ(1000),
        .BAUD_RATE       (100),
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .data_in       (din),
        .data_valid_in (dvalid),
        .data_ready_out(dready),
        .tx_wire_out   (tx),
        .busy_out      (busy),
        .fifo_count_out(fcount)
    );

    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } frame_t;

    frame_t     frq[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         full_cnt_seen = -1;

    // Line decoder: records every complete frame seen on tx, its start cycle,
    // its data bits and whether each bit slot held one level for a whole period.
    initial begin : line_monitor
        logic   samples [FRAME];
        int     n;
        bit     active;
        frame_t f;
        active = 0;
        n      = 0;
        forever begin
            @(negedge clk);
            if (rst_q === 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active     = 1;
                    samples[0] = 1'b0;
                    n          = 1;
                    f.start    = cyc;
                end
            end else begin
                samples[n] = tx;
                n++;
            end
            if (active && n == FRAME) begin
                f.ok = 1;
                for (int s = 0; s < DW + 2; s++)
                    for (int j = 0; j < BP; j++)
                        if (samples[s*BP+j] !== samples[s*BP]) f.ok = 0;
                if (samples[0] !== 1'b0 || samples[FRAME-BP] !== 1'b1) f.ok = 0;
                for (int b = 0; b < DW; b++) f.data[b] = samples[(b+1)*BP];
                frq.push_back(f);
                active = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w, output int acc);
        int t;
        t      = 0;
        din    = w;
        dvalid = 1'b1;
        while (dready !== 1'b1 && t < 1000) begin
            if (full_cnt_seen < 0) full_cnt_seen = int'(fcount);
            @(negedge clk);
            t++;
        end
        check("push_ready", dready, 1);
        @(negedge clk);
        acc    = cyc;
        dvalid = 1'b0;
        exp_q.push_back(w);
    endtask

    task automatic wait_tx_low(output int t0);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("tx_low_wait", tx, 0);
        t0 = cyc;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int limit);
        int t;
        t = 0;
        while (frq.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("frames_seen", frq.size(), n);
    endtask

    task automatic drain(input string tag);
        frame_t f;
        while (frq.size() > 0) begin
            f = frq.pop_front();
            check({tag, "_frame_ok"}, f.ok, 1);
            check({tag, "_has_expected"}, (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check({tag, "_data"}, f.data, exp_q.pop_front());
        end
        check({tag, "_all_sent"}, exp_q.size(), 0);
    endtask

    initial begin
        int     acc;
        int     acc2;
        int     t0;
        int     t;
        int     low_seen;
        logic [7:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fcount, 0);
        check("rst_ready", dready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", dready, 1);
        check("idle_tx", tx, 1);

        // Single word: latency, framing, busy duration
        push(8'hA3, acc);
        wait_tx_low(t0);
        check("t1_latency", t0 - acc, 2);
        check("t1_busy_high", busy, 1);
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("t1_busy_fall", cyc - t0, FRAME);
        check("t1_tx_idle", tx, 1);
        wait_frames(1, 200);
        drain("t1");

        // Two words back-to-back, no gap
        push(8'h55, acc);
        push(8'h0F, acc2);
        check("t2_accept_consecutive", acc2 - acc, 1);
        wait_frames(2, 400);
        if (frq.size() == 2) check("t2_gap", frq[1].start - frq[0].start, FRAME);
        drain("t2");

        // Hold valid with six words: ready drops at a full FIFO, order kept
        full_cnt_seen = -1;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i * 17), acc);
        check("t3_full_count", full_cnt_seen, DEPTH);
        wait_frames(6, 1000);
        drain("t3");

        // Push at the STOP->START boundary with two queued
        push(8'hC1, acc);
        push(8'hC2, acc);
        push(8'hC3, acc);
        wait_tx_low(t0);
        check("t6_count_pre", fcount, 2);
        wait_cycle(t0 + FRAME - 2);
        check("t6_count_before", fcount, 2);
        din    = 8'hC4;
        dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
        exp_q.push_back(8'hC4);
        check("t6_count_boundary", fcount, 2);
        wait_frames(4, 600);
        if (frq.size() == 4) check("t6_gap", frq[1].start - frq[0].start, FRAME);
        drain("t6");

        // Reset during data bit 3 with two words queued
        push(8'hE7, acc);
        push(8'h3C, acc);
        push(8'h99, acc);
        wait_tx_low(t0);
        check("t4_count_pre", fcount, 2);
        wait_cycle(t0 + 4 * BP + 4);
        rst = 1'b1;
        @(negedge clk);
        check("t4_ready_in_reset", dready, 0);
        rst = 1'b0;
        check("t4_tx", tx, 1);
        check("t4_count", fcount, 0);
        check("t4_busy", busy, 0);
        exp_q.delete();
        low_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1;
        end
        check("t4_line_quiet", low_seen, 0);
        check("t4_no_frame", frq.size(), 0);
        check("t4_busy_after", busy, 0);

        // Boundary data patterns
        push(8'h00, acc);
        push(8'hFF, acc);
        push(8'h81, acc);
        wait_frames(3, 600);
        drain("t5");

        // Random words with random spacing
        for (int i = 0; i < 10; i++) begin
            w = 8'($urandom);
            push(w, acc);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        wait_frames(10, 3000);
        drain("rand");
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("end_idle_busy", busy, 0);
        check("end_idle_count", fcount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
